// File: rtl/srcnn_residual.sv
// srcnn_residual: forks video pixels to the SRCNN core and a delay FIFO, then rejoins
// the core's signed residual with the delayed pixel (bypass / residual / core-only per frame).
module srcnn_residual #(
    parameter int HEIGHT         = 600,
    parameter int WIDTH          = 800,
    parameter int CHANNELS       = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int RESIDUAL_WIDTH = 8,
    parameter int FIFO_DEPTH     = 2048
) (
    input  logic                               clock_i,
    input  logic                               reset_ni,
    input  logic [1:0]                         mode_i,
    output logic [1:0]                         mode_o,
    output logic                               error_o,
    input  logic                               slave_tvalid_i,
    output logic                               slave_tready_o,
    input  logic [CHANNELS*DATA_WIDTH-1:0]     slave_tdata_i,
    input  logic                               slave_tlast_i,
    output logic                               core_m_tvalid_o,
    input  logic                               core_m_tready_i,
    output logic [CHANNELS*DATA_WIDTH-1:0]     core_m_tdata_o,
    output logic                               core_m_tlast_o,
    input  logic                               core_s_tvalid_i,
    output logic                               core_s_tready_o,
    input  logic [CHANNELS*RESIDUAL_WIDTH-1:0] core_s_tdata_i,
    input  logic                               core_s_tlast_i,
    output logic                               master_tvalid_o,
    input  logic                               master_tready_i,
    output logic [CHANNELS*DATA_WIDTH-1:0]     master_tdata_o,
    output logic                               master_tlast_o
);
    localparam int FRAME = HEIGHT * WIDTH;
    localparam int CW    = $clog2(FRAME);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = CHANNELS * DATA_WIDTH;
    localparam int SW    = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d, in_mode;
    logic [CW-1:0]     in_cnt_q, out_cnt_q;
    logic [AW:0]       wr_q, rd_q;
    logic [PW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     fifo_px, join_px, data_q;
    logic [SW-1:0]     sum;
    logic              valid_q, last_q, error_q;
    logic              open, full, not_empty, in_last, out_last, accept, push, pop, fire, src_ok;
    logic              in_byp, in_core, out_byp, out_core, emit_last;
    logic              unused_tlast;

    assign unused_tlast = slave_tlast_i;

    // Before the first beat of a frame the fork already follows the mode about to be latched.
    assign in_mode   = (state_q == IDLE) ? mode_i : mode_q;
    assign in_core   = in_mode == 2'd2;
    assign in_byp    = in_mode == 2'd0 || in_mode == 2'd3;
    assign out_core  = mode_q == 2'd2;
    assign out_byp   = mode_q == 2'd0 || mode_q == 2'd3;
    assign in_last   = in_cnt_q == CW'(FRAME - 1);
    assign out_last  = out_cnt_q == CW'(FRAME - 1);
    assign full      = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign not_empty = wr_q != rd_q;
    assign fifo_px   = mem[rd_q[AW-1:0]];

    assign open            = reset_ni && state_q != DRAIN;
    assign slave_tready_o  = open && (in_core ? core_m_tready_i : !full && (in_byp || core_m_tready_i));
    assign core_m_tvalid_o = open && !in_byp && slave_tvalid_i && (in_core || !full);
    assign core_m_tdata_o  = reset_ni ? slave_tdata_i : '0;
    assign core_m_tlast_o  = in_last;
    assign accept          = slave_tvalid_i && slave_tready_o;
    assign push            = accept && !in_core;

    assign src_ok          = out_core ? core_s_tvalid_i : not_empty && (out_byp || core_s_tvalid_i);
    assign fire            = reset_ni && (!valid_q || master_tready_i) && src_ok;
    assign pop             = fire && !out_core;
    assign core_s_tready_o = fire && !out_byp;
    assign emit_last       = valid_q && master_tready_i && last_q;

    assign master_tvalid_o = valid_q;
    assign master_tdata_o  = data_q;
    assign master_tlast_o  = last_q;
    assign mode_o          = mode_q;
    assign error_o         = error_q;

    // Saturating per-channel join; two guard bits catch both underflow and overflow.
    always_comb begin
        join_px = fifo_px;
        sum     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum = {{(SW - RESIDUAL_WIDTH){core_s_tdata_i[c*RESIDUAL_WIDTH + RESIDUAL_WIDTH - 1]}},
                   core_s_tdata_i[c*RESIDUAL_WIDTH +: RESIDUAL_WIDTH]}
                + (out_core ? SW'(0) : {2'b00, fifo_px[c*DATA_WIDTH +: DATA_WIDTH]});
            if (!out_byp)
                join_px[c*DATA_WIDTH +: DATA_WIDTH] = sum[SW-1] ? '0 : (sum[SW-2] ? '1 : sum[DATA_WIDTH-1:0]);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE:    if (accept) begin
                         state_d = RUN;
                         mode_d  = mode_i;
                     end
            RUN:     if (accept && in_last && mode_i != mode_q) state_d = DRAIN;
            DRAIN:   if (emit_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            if (accept) in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (fire) begin
                valid_q   <= 1'b1;
                data_q    <= join_px;
                last_q    <= out_last;
                out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
            end else if (master_tready_i) begin
                valid_q <= 1'b0;
            end
            if (core_s_tready_o && core_s_tvalid_i && core_s_tlast_i != out_last) error_q <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) mem[wr_q[AW-1:0]] <= slave_tdata_i;
    end
endmodule
